layer_out_scheduler: RTL and testbench

- Inter-layer scheduler between a parallel Layer output (NN neurons x DATA_WIDTH bits, per-neuron valid) and the serial input of the next Layer.
- Captures a complete output vector into a two-entry ping-pong store and streams it word-by-word under a valid/ready handshake.
- The producing layer may finish a new vector while the previous one is still draining.
- Reports busy, drop count and a sticky overflow flag for the AXI-Lite status path.

---
 rtl/nn_pkg.sv | 28 ++
 rtl/layer_vec_buffer.sv | 63 ++++++
 rtl/layer_out_scheduler.sv | 135 +++++++++++++
 tb/tb_layer_out_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants for the NN layer datapath: default word width, scheduler
// state encoding and AXI-Lite status register layout.
package nn_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_OVF_BIT  = 1;
    localparam int unsigned STAT_DROP_LSB = 8;
    localparam int unsigned STAT_DROP_W   = 8;

    function automatic logic [31:0] pack_status(
        input logic                   busy,
        input logic                   ovf,
        input logic [STAT_DROP_W-1:0] drop_cnt
    );
        logic [31:0] word;
        word = '0;
        word[STAT_BUSY_BIT] = busy;
        word[STAT_OVF_BIT]  = ovf;
        word[STAT_DROP_LSB +: STAT_DROP_W] = drop_cnt;
        return word;
    endfunction

endpackage

// File: rtl/layer_vec_buffer.sv
// Two-entry ping-pong store for complete layer output vectors with per-entry
// full flags and a word-granular read port.
module layer_vec_buffer
    import nn_pkg::*;
#(
    parameter int unsigned NN         = 30,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int unsigned IDX_W     = $clog2(NN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  logic [NN*DATA_WIDTH-1:0] wr_data,
    input  logic                     rel_en,
    input  logic                     rel_sel,
    input  logic                     rd_sel,
    input  logic [IDX_W-1:0]         idx,
    output logic [DATA_WIDTH-1:0]    word,
    output logic [1:0]               full,
    output logic [1:0]               full_nxt
);

    logic [NN*DATA_WIDTH-1:0] mem [2];
    logic [NN*DATA_WIDTH-1:0] sel_vec;

    // A write to an entry released in the same cycle leaves it full.
    always_comb begin
        full_nxt = full;
        if (rel_en) begin
            full_nxt[rel_sel] = 1'b0;
        end
        if (wr_en) begin
            full_nxt[wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
        end else begin
            full <= full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_sel] <= wr_data;
        end
    end

    assign sel_vec = mem[rd_sel];

    always_comb begin
        word = '0;
        for (int unsigned k = 0; k < NN; k++) begin
            if (idx == IDX_W'(k)) begin
                word = sel_vec[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/layer_out_scheduler.sv
// Captures a full parallel layer output vector on the rising edge of
// all-valid and streams it word by word to the next layer.
module layer_out_scheduler
    import nn_pkg::*;
#(
    parameter int unsigned NN         = 30,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                     s_axi_aclk,
    input  logic                     s_axi_aresetn,
    input  logic [NN-1:0]            in_valid,
    input  logic [NN*DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     drop_cnt,
    output logic                     ovf,
    input  logic                     clr_stats
);

    localparam int unsigned     IDX_W    = $clog2(NN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

    logic                  all_v;
    logic                  all_v_q;
    logic                  cap;
    logic                  avail;
    logic                  wr_en;
    logic                  drop;
    logic                  rel;
    logic                  at_last;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [0:0]            state;
    logic [IDX_W-1:0]      idx;
    logic [1:0]            full;
    logic [1:0]            full_nxt;
    logic [DATA_WIDTH-1:0] word;

    assign all_v   = &in_valid;
    assign cap     = all_v & ~all_v_q;
    assign at_last = (idx == LAST_IDX);
    assign rel     = (state == ST_SEND) && out_ready && at_last;

    // The buffer under the write pointer is reusable if it drains this cycle.
    assign avail = !full[wr_ptr] || (rel && (rd_ptr == wr_ptr));
    assign wr_en = cap && avail;
    assign drop  = cap && !avail;

    layer_vec_buffer #(
        .NN         (NN),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk      (s_axi_aclk),
        .rst_n    (s_axi_aresetn),
        .wr_en    (wr_en),
        .wr_sel   (wr_ptr),
        .wr_data  (in_data),
        .rel_en   (rel),
        .rel_sel  (rd_ptr),
        .rd_sel   (rd_ptr),
        .idx      (idx),
        .word     (word),
        .full     (full),
        .full_nxt (full_nxt)
    );

    assign out_valid = (state == ST_SEND);
    assign out_last  = out_valid && at_last;
    assign out_data  = out_valid ? word : '0;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            all_v_q <= 1'b0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
            idx     <= '0;
        end else begin
            all_v_q <= all_v;
            busy    <= |full_nxt;
            if (wr_en) begin
                wr_ptr <= ~wr_ptr;
            end
            if (rel) begin
                rd_ptr <= ~rd_ptr;
            end
            // Entering SEND on the write edge gives first-word latency of one cycle.
            case (state)
                ST_IDLE: begin
                    idx <= '0;
                    if (|full_nxt) begin
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (at_last) begin
                            idx <= '0;
                            if (!(|full_nxt)) begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            drop_cnt <= '0;
            ovf      <= 1'b0;
        end else if (clr_stats) begin
            drop_cnt <= drop ? CNT_WIDTH'(1) : '0;
            ovf      <= drop;
        end else if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_layer_out_scheduler.sv
// Directed and randomized bench for layer_out_scheduler against a
// vector-queue reference model.
module tb_layer_out_scheduler;

    localparam int unsigned NN  = 30;
    localparam int unsigned DW  = 16;
    localparam int unsigned CW  = 8;

    logic               clk;
    logic               rst_n;
    logic [NN-1:0]      in_valid;
    logic [NN*DW-1:0]   in_data;
    logic [DW-1:0]      out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               busy;
    logic [CW-1:0]      drop_cnt;
    logic               ovf;
    logic               clr_stats;

    layer_out_scheduler #(
        .NN         (NN),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .busy          (busy),
        .drop_cnt      (drop_cnt),
        .ovf           (ovf),
        .clr_stats     (clr_stats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
    } exp_t;

    // Model: queue of words still owed, number of vectors held, stats.
    exp_t        exp_q[$];
    int          occ;
    bit          prev_all;
    int          m_drop;
    bit          m_ovf;
    int          dut_hs;
    int          total;
    int          passed;
    int          failed;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        occ      = 0;
        prev_all = 1'b0;
        m_drop   = 0;
        m_ovf    = 1'b0;
    endtask

    // Check outputs of the current cycle at negedge, then advance the model.
    task automatic cycle();
        bit   cap;
        bit   drop;
        exp_t e;
        @(negedge clk);
        chk("busy", busy, occ != 0);
        chk("out_valid", out_valid, occ != 0);
        if (occ != 0 && exp_q.size() != 0) begin
            chk("out_data", out_data, exp_q[0].data);
            chk("out_last", out_last, exp_q[0].last);
        end
        chk("drop_cnt", drop_cnt, m_drop);
        chk("ovf", ovf, m_ovf);
        if (out_valid && out_ready) dut_hs++;

        if (occ != 0 && out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.last) occ--;
        end
        cap      = (&in_valid) && !prev_all;
        prev_all = &in_valid;
        drop     = 1'b0;
        if (cap) begin
            if (occ < 2) begin
                for (int k = 0; k < NN; k++) begin
                    e.data = in_data[k*DW +: DW];
                    e.last = (k == NN - 1);
                    exp_q.push_back(e);
                end
                occ++;
            end else begin
                drop = 1'b1;
            end
        end
        if (clr_stats) begin
            m_drop = drop ? 1 : 0;
            m_ovf  = drop;
        end else if (drop) begin
            if (m_drop < (1 << CW) - 1) m_drop++;
            m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_vec();
        for (int k = 0; k < NN; k++) in_data[k*DW +: DW] = DW'($urandom);
    endtask

    task automatic pulse();
        rand_vec();
        in_valid = '1;
        cycle();
        in_valid = '0;
        cycle();
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 400 && occ != 0; i++) cycle();
        cycle();
        chk(tag, busy, 1'b0);
    endtask

    int w0;

    initial begin
        total = 0; passed = 0; failed = 0; dut_hs = 0;
        rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0; clr_stats = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop_cnt", drop_cnt, '0);
        chk("rst_ovf", ovf, 1'b0);
        #2 rst_n = 1'b1;
        repeat (2) cycle();

        // Single ramp vector, ready high
        out_ready = 1'b1;
        for (int k = 0; k < NN; k++) in_data[k*DW +: DW] = DW'(16'h0100 + k);
        w0 = dut_hs;
        in_valid = '1;
        cycle();
        in_valid = '0;
        for (int i = 0; i < 35; i++) cycle();
        chk("single_words", dut_hs - w0, NN);

        // Backpressure 1,0,0,1
        w0 = dut_hs;
        rand_vec();
        in_valid = '1;
        out_ready = 1'b1;
        cycle();
        in_valid = '0;
        for (int i = 1; i < 400 && occ != 0; i++) begin
            out_ready = (i % 4 == 0) || (i % 4 == 3);
            cycle();
        end
        chk("bp_words", dut_hs - w0, NN);
        drain("bp_idle");

        // Two vectors 5 cycles apart
        w0 = dut_hs;
        pulse();
        repeat (3) cycle();
        pulse();
        drain("two_idle");
        chk("two_words", dut_hs - w0, 2 * NN);
        chk("two_drop", drop_cnt, '0);

        // Three vectors while stalled
        out_ready = 1'b0;
        repeat (3) pulse();
        chk("three_drop", drop_cnt, 8'd1);
        chk("three_ovf", ovf, 1'b1);
        w0 = dut_hs;
        drain("three_idle");
        chk("three_words", dut_hs - w0, 2 * NN);

        // Held all-ones, random ready
        w0 = dut_hs;
        rand_vec();
        in_valid = '1;
        for (int i = 0; i < 50; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        // Partial valid with bit 7 low
        in_valid = '1;
        in_valid[7] = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        in_valid = '0;
        drain("held_idle");
        chk("held_words", dut_hs - w0, NN);
        in_valid = '1;
        in_valid[7] = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        chk("partial_busy", busy, 1'b0);
        in_valid = '0;
        cycle();

        // Reset at word 12 of a burst
        w0 = dut_hs;
        pulse();
        for (int i = 0; i < 60 && (dut_hs - w0) < 12; i++) cycle();
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_drop", drop_cnt, '0);
        chk("mid_rst_ovf", ovf, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        w0 = dut_hs;
        for (int i = 0; i < 10; i++) cycle();
        chk("post_rst_silent", dut_hs - w0, 0);

        // clr_stats concurrent with a drop
        out_ready = 1'b0;
        repeat (4) pulse();
        chk("pre_clr_drop", drop_cnt, 8'd2);
        rand_vec();
        in_valid = '1;
        clr_stats = 1'b1;
        cycle();
        in_valid = '0;
        clr_stats = 1'b0;
        cycle();
        chk("clr_drop", drop_cnt, 8'd1);
        chk("clr_ovf", ovf, 1'b1);

        // Saturation then plain clear
        for (int i = 0; i < 260; i++) pulse();
        chk("sat_drop", drop_cnt, 8'hFF);
        clr_stats = 1'b1;
        cycle();
        clr_stats = 1'b0;
        cycle();
        chk("clr_only_drop", drop_cnt, '0);
        chk("clr_only_ovf", ovf, 1'b0);
        drain("sat_idle");

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    in_valid = '1;
                2:       in_valid = NN'($urandom);
                default: in_valid = '0;
            endcase
            rand_vec();
            out_ready = ($urandom_range(0, 3) != 0);
            clr_stats = ($urandom_range(0, 63) == 0);
            cycle();
        end
        in_valid = '0;
        clr_stats = 1'b0;
        drain("rand_idle");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
